fp_capture: RTL and testbench
=============================

Name: fp_capture

Overview:
- Downstream consumer of fp_counter's 8-bit value output; an armed pre/post-trigger snapshot buffer.
- Samples the value on a strobe into a DEPTH-entry ring buffer.
- Detects a threshold crossing, records POST samples after it, then streams the window out oldest-first over a valid/ready port.
- Sits beside fp_counter inside the peripheral harness; the register interface arms it and drains it.

Parameters:
- DEPTH, 16, ring-buffer entries; power of two, 4..64.
- AW, $clog2(DEPTH), pointer/count width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- value_in  in  8  fp_counter value, compared as raw unsigned code
- sample_en  in  1  capture strobe, one sample per high cycle
- arm  in  1  single-cycle start pulse; honoured only in IDLE
- abort  in  1  return to IDLE from any state; wins over all other inputs
- trig_level  in  8  threshold
- trig_falling  in  1  0 = rising crossing, 1 = falling crossing
- post_len  in  AW  samples stored after the trigger sample (0..DEPTH-1)
- rd_data  out  8  readout sample
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts
- rd_last  out  1  marks the final readout sample
- busy  out  1  state != IDLE
- triggered  out  1  sticky; set at trigger, cleared on arm or abort

Behaviour:
- Reset values: state IDLE; all pointers and counts 0; rd_valid, rd_last, busy, triggered = 0; rd_data = 0; prev-valid flag 0.
- States: IDLE, ARMED, POST, READ.
- IDLE --arm--> ARMED.
  - On entry: write pointer 0, fill 0, prev-valid 0; post_len and trig_falling latched.
- ARMED: on each sample_en cycle:
  - write value_in at wptr; wptr++ with wrap mod DEPTH; fill saturates at DEPTH;
  - store value_in as prev; set prev-valid.
- Trigger evaluation (ARMED only):
  - needs prev-valid = 1 and sample_en = 1;
  - rising: prev < trig_level and value_in >= trig_level;
  - falling: prev >= trig_level and value_in < trig_level.
  - First sample after arm never triggers.
- Trigger cycle:
  - the trigger sample is written;
  - triggered = 1 on the next edge;
  - post_len = 0 goes directly to READ, else go to POST with remaining = post_len.
- POST: each sample_en writes a sample and decrements remaining; the write that makes remaining 0 moves to READ on the same edge.
- READ entry:
  - rptr = (wptr - fill) mod DEPTH, using post-write wptr and fill;
  - rd_cnt = fill;
  - rd_valid rises the cycle after entry, a registered output.
- READ handshake:
  - transfer when rd_valid && rd_ready;
  - rd_data is stable while rd_valid && !rd_ready;
  - rd_last = 1 with the final sample.
  - After the last transfer: rd_valid = 0 and state IDLE on the next edge.
  - Throughput is one sample per cycle with rd_ready held high.
- Sampling rule: sample_en is ignored in IDLE and READ; no buffer writes in those states.
- Window length: fill < DEPTH (trigger came early) streams exactly fill samples. Otherwise DEPTH samples: DEPTH-1-post_len pre-trigger, the trigger sample, then post_len post-trigger.
- abort:
  - next edge: state IDLE, rd_valid = 0, triggered = 0;
  - buffer contents are don't-care.
- Simultaneous events:
  - arm and abort together: abort wins;
  - arm outside IDLE is ignored.
- Async reset mid-READ: outputs drop immediately to reset values.

Optional Feature:
- Macro FP_CAPTURE_TIMESTAMP_EN.
- Defined:
  - adds output trig_time[15:0] (reset 0);
  - a cycle counter is cleared on arm and increments every clk in ARMED, saturating at 16'hFFFF;
  - its value at the trigger edge is latched into trig_time, which holds until the next arm;
  - abort does not clear trig_time.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fp_capture_pkg:
  - state enum (IDLE, ARMED, POST, READ);
  - default DEPTH constant;
  - TS_W = 16.
- Sub-module fp_capture_ring: a DEPTH x 8 register array with one write port and one registered read port. It is the natural split from the control FSM in fp_capture.

Test Plan:
1. Rising trigger: arm, trig_level=0x40, post_len=3; feed 0x00,0x10,…,0x70 on sample_en. Require trigger on sample 0x40, fill=8, and readout 0x00..0x70 in order with rd_last on 0x70.
2. Full wrap: DEPTH=16, post_len=4, trigger at sample index 30 of an incrementing ramp. Require 16 samples out: indices 19..34, with the trigger at the 12th position.
3. Backpressure: toggle rd_ready 1,0,0,1… during READ. Require rd_data stable while stalled, no sample lost or duplicated, and rd_valid low after the last transfer.
4. No false trigger: arm with value already 0x80, rising, level 0x40; hold at 0x80. Require no trigger. Then feed 0x20 then 0x50; require trigger on 0x50.
5. abort during POST with simultaneous arm. Require IDLE on the next edge and triggered=0. A subsequent arm operates normally.
6. Async reset asserted mid-READ. Require rd_valid, busy and triggered to go to 0 immediately. With FP_CAPTURE_TIMESTAMP_EN defined, check trig_time equals arm-to-trigger cycles, e.g. 25.

Source files
------------

// File: rtl/fp_capture_pkg.sv
// rtl/fp_capture_pkg.sv - shared types and constants for the fp_capture snapshot buffer
package fp_capture_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      READ  = 2'd3
   } state_t;

   localparam int DEFAULT_DEPTH = 16;
   localparam int TS_W          = 16;

endpackage

// File: rtl/fp_capture_ring.sv
// rtl/fp_capture_ring.sv - DEPTH x 8 sample store, one write port, one registered read port
module fp_capture_ring #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // read register only moves on rd_en so a stalled consumer sees stable data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fp_capture.sv
// rtl/fp_capture.sv - armed pre/post-trigger snapshot of fp_counter value, streamed oldest-first
// Optional trigger timestamp output under FP_CAPTURE_TIMESTAMP_EN.
module fp_capture
   import fp_capture_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    value_in,
   input  logic          sample_en,
   input  logic          arm,
   input  logic          abort,
   input  logic [7:0]    trig_level,
   input  logic          trig_falling,
   input  logic [AW-1:0] post_len,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic          rd_last,
   output logic          busy,
   output logic          triggered
`ifdef FP_CAPTURE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0] trig_time
`endif
);

   localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   state_t        state, state_nx;
   logic [AW-1:0] wptr, rptr, remaining, post_len_q;
   logic [AW:0]   fill, rd_cnt;
   logic [7:0]    prev;
   logic          prev_valid, falling_q;
   logic [AW-1:0] wptr_nx;
   logic [AW:0]   fill_nx;
   logic          rise, fall, trig_hit, post_done, xfer, load, wr_en;

   assign wptr_nx   = wptr + 1'b1;
   assign fill_nx   = (fill == FULL) ? fill : fill + 1'b1;
   assign rise      = (prev <  trig_level) && (value_in >= trig_level);
   assign fall      = (prev >= trig_level) && (value_in <  trig_level);
   assign trig_hit  = (state == ARMED) && sample_en && prev_valid && (falling_q ? fall : rise);
   assign post_done = (state == POST) && sample_en && (remaining == AW'(1));
   assign xfer      = rd_valid && rd_ready;
   assign load      = (state == READ) && (rd_cnt != '0) && (!rd_valid || rd_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:  if (arm) state_nx = ARMED;
            ARMED: if (trig_hit) state_nx = (post_len_q == '0) ? READ : POST;
            POST:  if (post_done) state_nx = READ;
            READ:  if (xfer && rd_cnt == '0) state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      busy  = (state != IDLE);
      wr_en = sample_en && ((state == ARMED) || (state == POST));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr       <= '0;
         rptr       <= '0;
         fill       <= '0;
         rd_cnt     <= '0;
         remaining  <= '0;
         post_len_q <= '0;
         falling_q  <= 1'b0;
         prev       <= '0;
         prev_valid <= 1'b0;
         triggered  <= 1'b0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
      end else if (abort) begin
         triggered <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (arm) begin
               wptr       <= '0;
               fill       <= '0;
               prev_valid <= 1'b0;
               post_len_q <= post_len;
               falling_q  <= trig_falling;
               triggered  <= 1'b0;
            end
            ARMED, POST: begin
               if (wr_en) begin
                  wptr       <= wptr_nx;
                  fill       <= fill_nx;
                  prev       <= value_in;
                  prev_valid <= 1'b1;
               end
               if (trig_hit) begin
                  triggered <= 1'b1;
                  remaining <= post_len_q;
               end else if (state == POST && sample_en) begin
                  remaining <= remaining - 1'b1;
               end
               // READ is only entered on a write, so the post-write pointer/fill apply
               if (state_nx == READ) begin
                  rptr   <= wptr_nx - fill_nx[AW-1:0];
                  rd_cnt <= fill_nx;
               end
            end
            READ: begin
               if (load) begin
                  rptr     <= rptr + 1'b1;
                  rd_cnt   <= rd_cnt - 1'b1;
                  rd_valid <= 1'b1;
                  rd_last  <= (rd_cnt == CNT_ONE);
               end else if (xfer) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
               end
            end
         endcase
      end
   end

   fp_capture_ring #(.DEPTH(DEPTH), .AW(AW)) u_ring (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wptr),
      .wr_data (value_in),
      .rd_en   (load),
      .rd_addr (rptr),
      .rd_data (rd_data)
   );

`ifdef FP_CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt, ts_inc;

   assign ts_inc = (ts_cnt == '1) ? ts_cnt : ts_cnt + 1'b1;

   // latch the value the counter takes on the trigger edge: arm-to-trigger cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt    <= '0;
         trig_time <= '0;
      end else if (state == IDLE && arm && !abort) begin
         ts_cnt    <= '0;
         trig_time <= '0;
      end else if (state == ARMED) begin
         ts_cnt <= ts_inc;
         if (trig_hit && !abort) trig_time <= ts_inc;
      end
   end
`endif

endmodule

// File: tb/tb_fp_capture.sv
// tb/tb_fp_capture.sv - self-checking bench for fp_capture: trigger table, directed corners, random model
module tb_fp_capture;

   localparam int DEPTH = 16;
   typedef logic [7:0] u8;

   typedef struct {
      u8    prev;
      u8    cur;
      u8    lvl;
      logic fall;
      logic exp_trig;
   } tvec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] value_in = '0;
   logic       sample_en = 1'b0;
   logic       arm = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] trig_level = '0;
   logic       trig_falling = 1'b0;
   logic [3:0] post_len = '0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic       rd_last;
   logic       busy;
   logic       triggered;
`ifdef FP_CAPTURE_TIMESTAMP_EN
   logic [15:0] trig_time;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: everything stored since arm, plus trigger bookkeeping
   u8    hist[$];
   int   m_phase = 0;
   int   m_rem, m_post;
   logic m_fall, m_have;
   bit   m_trig = 0;
   u8    m_prev, m_level;

   always #5 clk = ~clk;

   fp_capture #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .value_in     (value_in),
      .sample_en    (sample_en),
      .arm          (arm),
      .abort        (abort),
      .trig_level   (trig_level),
      .trig_falling (trig_falling),
      .post_len     (post_len),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_last      (rd_last),
      .busy         (busy),
      .triggered    (triggered)
`ifdef FP_CAPTURE_TIMESTAMP_EN
      ,
      .trig_time    (trig_time)
`endif
   );

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_arm(input u8 lvl, input logic fall, input int post);
      trig_level   = lvl;
      trig_falling = fall;
      post_len     = 4'(post);
      arm          = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      hist.delete();
      m_phase = 1; m_have = 0; m_trig = 0;
      m_post = post; m_fall = fall; m_level = lvl;
      check("arm_busy", busy, 1);
      check("arm_trig_clr", triggered, 0);
   endtask

   task automatic feed(input u8 v, input bit se);
      value_in  = v;
      sample_en = se;
      if (se && m_phase == 1) begin
         if (m_have && (m_fall ? (m_prev >= m_level && v < m_level)
                               : (m_prev < m_level && v >= m_level))) begin
            m_trig = 1;
            if (m_post == 0) m_phase = 3;
            else begin m_phase = 2; m_rem = m_post; end
         end
         hist.push_back(v);
         m_prev = v;
         m_have = 1;
      end else if (se && m_phase == 2) begin
         hist.push_back(v);
         m_rem--;
         if (m_rem == 0) m_phase = 3;
      end
      @(negedge clk);
      sample_en = 1'b0;
      check("trig_flag", triggered, int'(m_trig));
      check("busy", busy, int'(m_phase != 0));
   endtask

   task automatic abort_seq(input logic with_arm);
      abort = 1'b1;
      arm   = with_arm;
      @(negedge clk);
      abort = 1'b0;
      arm   = 1'b0;
      m_phase = 0;
      m_trig  = 0;
      check("abort_busy", busy, 0);
      check("abort_trig", triggered, 0);
      check("abort_valid", rd_valid, 0);
   endtask

   // mode 0: ready held, 1: pattern 1,0,0,1, 2: random; stop_after >= 0 leaves mid-stream
   task automatic drain(input int mode, input u8 exp_q[$], input int stop_after);
      int   n, idx, to, pat;
      bit   stalled, r;
      u8    last_d;
      n = exp_q.size(); idx = 0; to = 0; pat = 0; stalled = 0; last_d = '0;
      check("rd_valid_entry", rd_valid, 0);
      while (idx < n && to < 200 && !(stop_after >= 0 && idx == stop_after)) begin
         case (mode)
            0:       r = 1;
            1:       r = (pat % 4 == 0) || (pat % 4 == 3);
            default: r = $urandom_range(0, 1) != 0;
         endcase
         pat++;
         rd_ready  = r;
         sample_en = $urandom_range(0, 1) != 0;
         value_in  = u8'($urandom);
         if (rd_valid) begin
            if (stalled) check("rd_stable", rd_data, last_d);
            if (r) begin
               check("rd_data", rd_data, exp_q[idx]);
               check("rd_last", rd_last, int'(idx == n - 1));
               idx++;
            end
            stalled = !r;
            last_d  = rd_data;
         end else if (mode == 0 && idx > 0) begin
            check("rd_gap", rd_valid, 1);
         end
         @(negedge clk);
         to++;
      end
      rd_ready  = 1'b0;
      sample_en = 1'b0;
      if (stop_after < 0) begin
         check("rd_count", idx, n);
         check("rd_valid_end", rd_valid, 0);
         check("busy_end", busy, 0);
         m_phase = 0;
      end
   endtask

   task automatic model_window(output u8 w[$]);
      int n;
      w.delete();
      n = (hist.size() > DEPTH) ? DEPTH : hist.size();
      for (int i = hist.size() - n; i < hist.size(); i++) w.push_back(hist[i]);
   endtask

   task automatic run_t1(input int mode);
      u8 e[$];
      do_arm(8'h40, 1'b0, 3);
      for (int i = 0; i < 8; i++) begin
         feed(u8'(i * 16), 1'b1);
         if (i == 3) check("t1_no_trig_0x30", triggered, 0);
         if (i == 4) check("t1_trig_0x40", triggered, 1);
      end
      for (int i = 0; i < 8; i++) e.push_back(u8'(i * 16));
      drain(mode, e, -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tvec_t tv[10];
      u8     e[$];
      tv[0] = '{8'h3F, 8'h40, 8'h40, 1'b0, 1'b1};
      tv[1] = '{8'h40, 8'h41, 8'h40, 1'b0, 1'b0};
      tv[2] = '{8'h3F, 8'h3F, 8'h40, 1'b0, 1'b0};
      tv[3] = '{8'h00, 8'hFF, 8'h40, 1'b0, 1'b1};
      tv[4] = '{8'h40, 8'h3F, 8'h40, 1'b1, 1'b1};
      tv[5] = '{8'h3F, 8'h00, 8'h40, 1'b1, 1'b0};
      tv[6] = '{8'h41, 8'h40, 8'h40, 1'b1, 1'b0};
      tv[7] = '{8'hFF, 8'h00, 8'h40, 1'b1, 1'b1};
      tv[8] = '{8'h00, 8'h05, 8'h00, 1'b0, 1'b0};
      tv[9] = '{8'hFE, 8'hFF, 8'hFF, 1'b0, 1'b1};

      #12;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_busy", busy, 0);
      check("rst_triggered", triggered, 0);
      check("rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tv[i]) begin
         do_arm(tv[i].lvl, tv[i].fall, 3);
         feed(tv[i].prev, 1'b1);
         feed(tv[i].cur, 1'b1);
         check("tbl_trig", triggered, int'(tv[i].exp_trig));
         abort_seq(1'b0);
      end

      run_t1(0);

      // full wrap: ramp with idle gaps, trigger at index 30, window 19..34
      do_arm(8'd30, 1'b0, 4);
      for (int i = 0; i < 35; i++) begin
         if (i % 5 == 2) feed(8'hAA, 1'b0);
         feed(u8'(i), 1'b1);
      end
      e.delete();
      for (int i = 19; i <= 34; i++) e.push_back(u8'(i));
      check("t2_trig_pos", int'(e[11]), 30);
      drain(2, e, -1);

      run_t1(1);

      // no false trigger while already above level
      do_arm(8'h40, 1'b0, 0);
      for (int i = 0; i < 5; i++) feed(8'h80, 1'b1);
      check("t4_no_trig_high", triggered, 0);
      feed(8'h20, 1'b1);
      check("t4_no_trig_drop", triggered, 0);
      feed(8'h50, 1'b1);
      check("t4_trig_0x50", triggered, 1);
      e = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h20, 8'h50};
      drain(0, e, -1);

      // abort during POST wins over a simultaneous arm
      do_arm(8'h40, 1'b0, 5);
      feed(8'h10, 1'b1);
      feed(8'h50, 1'b1);
      feed(8'h60, 1'b1);
      check("t5_in_post", busy, 1);
      abort_seq(1'b1);
      @(negedge clk);
      check("t5_still_idle", busy, 0);
      run_t1(0);

      for (int it = 0; it < 25; it++) begin
         int cnt;
         do_arm(u8'($urandom_range(8'h20, 8'hE0)), logic'($urandom_range(0, 1)), $urandom_range(0, 15));
         cnt = 0;
         while (m_phase != 3 && cnt < 400) begin
            feed(u8'($urandom), $urandom_range(0, 3) != 0);
            cnt++;
         end
         if (m_phase == 3) begin
            model_window(e);
            drain(it % 3, e, -1);
         end else begin
            abort_seq(1'b0);
         end
      end

      // async reset mid-READ
      do_arm(8'h40, 1'b0, 2);
      for (int i = 0; i < 24; i++) feed(8'h00, 1'b1);
      feed(8'h50, 1'b1);
      check("t6_trig", triggered, 1);
`ifdef FP_CAPTURE_TIMESTAMP_EN
      check("t6_trig_time", trig_time, 25);
`endif
      feed(8'h51, 1'b1);
      feed(8'h52, 1'b1);
      model_window(e);
      drain(0, e, 3);
      check("t6_valid_before_rst", rd_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", rd_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_trig", triggered, 0);
      check("t6_rst_last", rd_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_phase = 0;
      m_trig  = 0;
      @(negedge clk);
      run_t1(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
